serial_adder: RTL
=================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 1..64).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-005 SHALL have port a, input, WIDTH bits: operand A, captured on the accepting edge.
REQ-006 SHALL have port b, input, WIDTH bits: operand B, captured on the accepting edge.
REQ-007 SHALL have port cin, input, 1 bit: carry-in, captured on the accepting edge.
REQ-008 SHALL have port busy, output, 1 bit: high while in ADD.
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port sum, output, WIDTH bits: result, held from done until the next accepted start.
REQ-011 SHALL have port cout, output, 1 bit: carry out of the MSB.
REQ-012 SHALL have port ovf, output, 1 bit: signed overflow, equal to the carry into the MSB XOR cout.

Function
REQ-013 SHALL use the FSM states IDLE, ADD and DONE, encoded with a package enum.
REQ-014 SHALL, in IDLE with start=1, on that edge latch a, b and cin, clear the bit counter, and go to ADD.
REQ-015 SHALL, in ADD, process one bit per edge, LSB first, through one 1-bit full-adder cell, with the carry held in a flop between bits.
REQ-016 SHALL, on the edge that processes bit WIDTH-1, load cout and ovf, complete sum, and go to DONE.
REQ-017 SHALL make latency exactly WIDTH edges from the accepting edge to the edge that raises done.
REQ-018 SHALL hold done high for exactly one cycle (the DONE state), then return unconditionally to IDLE.
REQ-019 SHALL ignore start while in ADD or DONE; operands and the result SHALL be unaffected.
REQ-020 SHALL treat changes on a, b and cin after acceptance as having no effect on the operation in flight.
REQ-021 SHALL, for WIDTH=1, complete in 1 cycle and reproduce the 1-bit full-adder truth table, with ovf = cin XOR cout.
REQ-022 SHALL keep sum, cout and ovf stable from done until the next accepted start; during ADD, sum bits SHALL update progressively.
REQ-023 SHALL size the bit counter as $clog2(WIDTH)+1 bits, with no wrap before reaching WIDTH-1.

Reset
REQ-024 SHALL, while rst_n=0, immediately force state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, carry flop=0 and counter=0.
REQ-025 SHALL, on reset mid-operation, abandon the operation without a done pulse; the first start after release SHALL begin a fresh operation.

Configuration
REQ-026 SHALL compile in, when macro SERIAL_ADDER_SUB_EN is defined, an input port sub (1 bit, captured with the operands); sub=1 SHALL compute a - b by adding ~b with carry-in forced to 1 (cin ignored), and cout SHALL then mean no-borrow.
REQ-027 SHALL, when SERIAL_ADDER_SUB_EN is undefined, have no sub port and perform add-only operation.

Structure
REQ-028 SHALL place the state enum (IDLE/ADD/DONE) and the default-width constant in package serial_adder_pkg.
REQ-029 SHALL instantiate exactly one combinational sub-module fa_cell (inputs x, y, cin; outputs sum, cout) as the bit datapath.

Verification
REQ-030 SHALL cover: WIDTH=8, a=0xFF, b=0x01, cin=0 -> done 8 cycles after acceptance, sum=0x00, cout=1, ovf=0.
REQ-031 SHALL cover: WIDTH=8, a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1; then a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
REQ-032 SHALL cover: WIDTH=1, all 8 (a, b, cin) vectors -> {cout, sum} equal to a+b+cin, with done 1 cycle after each start.
REQ-033 SHALL cover: start re-asserted with new operands during ADD -> ignored; the result matches the first operands, with exactly one done pulse.
REQ-034 SHALL cover: rst_n pulsed low at bit 3 of an 8-bit operation -> outputs zero immediately, no done; a following 0x05+0x03 operation gives 0x08.
REQ-035 SHALL cover, with SERIAL_ADDER_SUB_EN defined: sub=1, a=0x05, b=0x07 -> sum=0xFE, cout=0, ovf=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Holds the FSM state encoding and the default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder.
// This is the only arithmetic in the serial datapath.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell per clock, LSB first, done after WIDTH edges.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' input that computes a - b.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int              CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] w_bLoad;
    logic             w_cinLoad;
    logic             w_faSum;
    logic             w_faCout;
    logic             w_lastBit;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is a + ~b + 1, so the incoming carry is forced high.
    assign w_bLoad   = sub ? ~b : b;
    assign w_cinLoad = sub | cin;
`else
    assign w_bLoad   = b;
    assign w_cinLoad = cin;
`endif

    assign w_lastBit = (r_cnt == LAST_BIT);

    fa_cell u_fa (
        .x    (r_a[0]),
        .y    (r_b[0]),
        .cin  (r_carry),
        .sum  (w_faSum),
        .cout (w_faCout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start) w_nextState = ADD;
            ADD:     if (w_lastBit) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Operands shift right so the cell always sees bit 0; result bits land in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= w_bLoad;
                        r_carry <= w_cinLoad;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                ADD: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_faCout;
                    r_sum   <= r_sum | (WIDTH'(w_faSum) << r_cnt);
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_lastBit) begin
                        r_cout <= w_faCout;
                        r_ovf  <= r_carry ^ w_faCout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (r_state == ADD);
    assign done = (r_state == DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule
